// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: instruction encodings, write-back select and load-type codes, write-back decode
package wb_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW   = 6'h2b;
    localparam logic [5:0] FN_JALR    = 6'h09, FN_MFHI   = 6'h10, FN_MFLO = 6'h12;
    localparam logic [4:0] RT_BLTZAL  = 5'h10, RT_BGEZAL = 5'h11, RS_MFC0 = 5'h00;

    typedef enum logic [2:0] {SEL_ALU, SEL_MDU, SEL_CP0, SEL_PC8, SEL_MEM} wb_sel_e;
    typedef enum logic [2:0] {LD_W, LD_H, LD_HU, LD_B, LD_BU} ld_type_e;

    typedef struct packed {
        logic       is_load;
        logic [4:0] dest;
        wb_sel_e    sel;
        ld_type_e   ld;
    } wb_dec_t;

    function automatic wb_dec_t wb_decode(input logic [31:0] ins);
        wb_dec_t    d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       link;
        logic       regimm_link;
        logic       mdu;
        logic       mfc0;
        logic       nodest;
        op          = ins[31:26];
        fn          = ins[5:0];
        rs          = ins[25:21];
        rt          = ins[20:16];
        regimm_link = op == OP_REGIMM && (rt == RT_BLTZAL || rt == RT_BGEZAL);
        link        = op == OP_JAL || regimm_link || (op == OP_SPECIAL && fn == FN_JALR);
        mdu         = op == OP_SPECIAL && (fn == FN_MFHI || fn == FN_MFLO);
        mfc0        = op == OP_COP0 && rs == RS_MFC0;
        nodest      = op inside {OP_REGIMM, OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_SB, OP_SH, OP_SW}
                      || (op == OP_COP0 && !mfc0);
        d.is_load   = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        d.ld        = op == OP_LB ? LD_B : op == OP_LBU ? LD_BU : op == OP_LH ? LD_H :
                      op == OP_LHU ? LD_HU : LD_W;
        d.sel       = d.is_load ? SEL_MEM : link ? SEL_PC8 : mdu ? SEL_MDU : mfc0 ? SEL_CP0 : SEL_ALU;
        d.dest      = (op == OP_JAL || regimm_link) ? 5'd31 : nodest ? 5'd0 :
                      op == OP_SPECIAL ? ins[15:11] : rt;
        return d;
    endfunction

endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: selects and sign/zero-extends the addressed byte or half of a load word
module wb_load_ext
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr10,
    input  logic [2:0]  ld_type,
    output logic [31:0] ext
);

    logic [15:0] half;
    logic [7:0]  bt;

    always_comb begin
        half = addr10[1] ? rdata[31:16] : rdata[15:0];
        bt   = rdata[{addr10, 3'b000} +: 8];
        ext  = ld_type == LD_H  ? {{16{half[15]}}, half} :
               ld_type == LD_HU ? {16'h0, half} :
               ld_type == LD_B  ? {{24{bt[7]}}, bt} :
               ld_type == LD_BU ? {24'h0, bt} : rdata;
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back; matches in-order read responses to loads and drives regfile/forwarding/trace
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int RESP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_last,
    output logic        allowin,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] mdu_i,
    input  logic [31:0] cp0_i,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok,
    input  logic        data_is_rd,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  fwd_addr,
    output logic        fwd_ready,
    output logic [31:0] fwd_data,
    output logic [31:0] debug_wb_pc,
    output logic        debug_wb_we
);

    localparam int PW = $clog2(RESP_DEPTH);

    logic [31:0]   buf_q [RESP_DEPTH];
    logic [31:0]   buf_d [RESP_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [31:0]   debug_wb_pc_q, debug_wb_pc_d;
    logic          debug_wb_we_q, debug_wb_we_d;
    wb_dec_t       dec;
    logic          push_req, head_avail, full, bypass_hit, ready_go, commit, pop, push;
    logic [31:0]   ld_raw, ld_ext;

    assign dec    = wb_decode(instr_i);
    assign ld_raw = cnt_q != '0 ? buf_q[rd_ptr_q] : data_rdata;

    wb_load_ext u_ext (
        .rdata   (ld_raw),
        .addr10  (alu_i[1:0]),
        .ld_type (dec.ld),
        .ext     (ld_ext)
    );

    always_comb begin
        push_req      = data_data_ok && data_is_rd;
        head_avail    = cnt_q != '0;
        full          = cnt_q == (PW+1)'(RESP_DEPTH);
        bypass_hit    = valid_last && dec.is_load && !head_avail && push_req;
        ready_go      = !dec.is_load || head_avail || bypass_hit;
        commit        = valid_last && ready_go && !reset;
        pop           = commit && dec.is_load && head_avail;
        push          = push_req && !bypass_hit && (!full || pop);
        buf_d         = buf_q;
        if (push) buf_d[wr_ptr_q] = data_rdata;
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d         = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        allowin       = !valid_last || ready_go;
        rf_we         = commit && dec.dest != 5'd0;
        rf_waddr      = dec.dest;
        rf_wdata      = dec.sel == SEL_MEM ? ld_ext :
                        dec.sel == SEL_MDU ? mdu_i :
                        dec.sel == SEL_CP0 ? cp0_i :
                        dec.sel == SEL_PC8 ? pc_i + 32'd8 : alu_i;
        fwd_addr      = (valid_last && !reset) ? dec.dest : 5'd0;
        fwd_ready     = ready_go && !reset;
        fwd_data      = rf_wdata;
        debug_wb_pc_d = commit ? pc_i : debug_wb_pc_q;
        debug_wb_we_d = commit ? rf_we : debug_wb_we_q;
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (reset) begin
            cnt_q         <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            debug_wb_pc_q <= '0;
            debug_wb_we_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            debug_wb_pc_q <= debug_wb_pc_d;
            debug_wb_we_q <= debug_wb_we_d;
        end
    end

    assign debug_wb_pc = debug_wb_pc_q;
    assign debug_wb_we = debug_wb_we_q;

    resp_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_req && !bypass_hit && full && !pop));

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors; expectations queued at issue, checked by a commit monitor
module tb_wb_stage;

    logic        clk, reset, valid_last, allowin;
    logic [31:0] pc_i, instr_i, alu_i, mdu_i, cp0_i, data_rdata;
    logic        data_data_ok, data_is_rd;
    logic        rf_we, fwd_ready, debug_wb_we;
    logic [4:0]  rf_waddr, fwd_addr;
    logic [31:0] rf_wdata, fwd_data, debug_wb_pc;

    wb_stage dut (
        .clk(clk), .reset(reset), .valid_last(valid_last), .allowin(allowin),
        .pc_i(pc_i), .instr_i(instr_i), .alu_i(alu_i), .mdu_i(mdu_i), .cp0_i(cp0_i),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok), .data_is_rd(data_is_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_addr(fwd_addr), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .debug_wb_pc(debug_wb_pc), .debug_wb_we(debug_wb_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 16'h0000};
    endfunction

    // Monitor: trace regs lag the model by one edge; every commit pops one expectation
    initial begin : monitor
        logic [31:0] dbg_pc_exp;
        logic        dbg_we_exp;
        exp_t        e;
        dbg_pc_exp = '0;
        dbg_we_exp = 1'b0;
        forever begin
            @(negedge clk);
            chk("dbg_pc", debug_wb_pc, dbg_pc_exp);
            chk("dbg_we", 32'(debug_wb_we), 32'(dbg_we_exp));
            if (reset) begin
                dbg_pc_exp = '0;
                dbg_we_exp = 1'b0;
            end else if (valid_last && allowin) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL commit: unexpected commit pc %h", pc_i);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_we", 32'(rf_we), 32'(e.we));
                    chk("rf_waddr", 32'(rf_waddr), 32'(e.wa));
                    chk("fwd_addr", 32'(fwd_addr), 32'(e.wa));
                    chk("fwd_ready", 32'(fwd_ready), 32'd1);
                    if (e.we) begin
                        chk("rf_wdata", rf_wdata, e.wd);
                        chk("fwd_data", fwd_data, e.wd);
                    end
                    dbg_pc_exp = e.pc;
                    dbg_we_exp = e.we;
                end
            end else begin
                chk("idle_rf_we", 32'(rf_we), 32'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                         input logic bp, input logic [31:0] bp_d,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd, output int n);
        exp_q.push_back('{we, wa, wd, pc});
        valid_last   = 1'b1;
        instr_i      = ins;
        pc_i         = pc;
        alu_i        = alu;
        data_data_ok = bp;
        data_is_rd   = 1'b1;
        data_rdata   = bp_d;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (allowin) break;
        end
        if (n == 20) begin
            total++;
            bad++;
            $display("FAIL timeout: pc %h never committed", pc);
        end
        @(posedge clk);
        #1 data_data_ok = 1'b0;
    endtask

    task automatic stall_load(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                              input int ns, input logic [31:0] d, input logic [4:0] wa,
                              input logic [31:0] wd);
        exp_q.push_back('{wa != 5'd0, wa, wd, pc});
        valid_last   = 1'b1;
        instr_i      = ins;
        pc_i         = pc;
        alu_i        = alu;
        data_data_ok = 1'b0;
        for (int i = 0; i < ns; i++) begin
            @(negedge clk);
            chk("stall_allowin", 32'(allowin), 32'd0);
            chk("stall_fwd_ready", 32'(fwd_ready), 32'd0);
            chk("stall_fwd_addr", 32'(fwd_addr), 32'(wa));
            @(posedge clk);
            #1;
        end
        data_data_ok = 1'b1;
        data_is_rd   = 1'b1;
        data_rdata   = d;
        @(negedge clk);
        chk("release_allowin", 32'(allowin), 32'd1);
        @(posedge clk);
        #1 data_data_ok = 1'b0;
        valid_last = 1'b0;
    endtask

    task automatic idle();
        valid_last = 1'b0;
        instr_i    = '0;
    endtask

    task automatic resp(input logic [31:0] d, input logic rd);
        data_data_ok = 1'b1;
        data_is_rd   = rd;
        data_rdata   = d;
        @(posedge clk);
        #1 data_data_ok = 1'b0;
    endtask

    initial begin : stim
        int n;
        reset = 1'b1; valid_last = 1'b0; instr_i = '0; pc_i = '0; alu_i = '0;
        mdu_i = 32'hAAAA5555; cp0_i = 32'hC0C00C0C; data_rdata = '0;
        data_data_ok = 1'b0; data_is_rd = 1'b0;
        @(negedge clk);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_fwd_addr", 32'(fwd_addr), 32'd0);
        chk("rst_fwd_ready", 32'(fwd_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue(enc_r(1, 2, 3, 6'h21), 32'hBFC00000, 32'h12345678, 0, 0, 1, 3, 32'h12345678, n);
        chk("addu_lat", n, 0);
        issue(enc_i(6'h20, 1, 4), 32'hBFC00004, 32'h00001003, 1, 32'h80FF0000, 1, 4, 32'hFFFFFF80, n);
        chk("lb_bypass_lat", n, 0);
        stall_load(enc_i(6'h23, 1, 10), 32'hBFC00008, 32'h00001000, 1, 32'h0BADF00D, 10, 32'h0BADF00D);
        stall_load(enc_i(6'h25, 1, 5), 32'hBFC0000C, 32'h00002002, 3, 32'hBEEF1234, 5, 32'h0000BEEF);

        idle();
        resp(32'h11111111, 1);
        resp(32'h22222222, 1);
        issue(enc_i(6'h23, 1, 6), 32'hBFC00010, 32'h00000100, 0, 0, 1, 6, 32'h11111111, n);
        chk("lw_fifo1_lat", n, 0);
        issue(enc_i(6'h23, 1, 7), 32'hBFC00014, 32'h00000104, 0, 0, 1, 7, 32'h22222222, n);
        chk("lw_fifo2_lat", n, 0);

        issue({6'h03, 26'h0100040}, 32'hBFC00100, 32'h0, 0, 0, 1, 31, 32'hBFC00108, n);
        idle();
        resp(32'h33333333, 1);
        issue(enc_i(6'h23, 1, 0), 32'hBFC00108, 32'h00000200, 0, 0, 0, 0, 32'h0, n);
        chk("lw_r0_lat", n, 0);
        issue(enc_i(6'h23, 1, 8), 32'hBFC0010C, 32'h00000204, 1, 32'h44444444, 1, 8, 32'h44444444, n);
        chk("lw_after_pop_lat", n, 0);

        issue(enc_r(0, 0, 9, 6'h10), 32'hBFC00110, 32'h0, 0, 0, 1, 9, 32'hAAAA5555, n);
        issue({6'h10, 5'h00, 5'd11, 5'd12, 11'h0}, 32'hBFC00114, 32'h0, 0, 0, 1, 11, 32'hC0C00C0C, n);
        issue({6'h01, 5'd1, 5'h10, 16'h0}, 32'hFFFFFFFC, 32'h0, 0, 0, 1, 31, 32'h00000004, n);
        issue(enc_i(6'h2b, 1, 3), 32'hBFC00118, 32'h00000300, 0, 0, 0, 0, 32'h0, n);
        issue(enc_i(6'h21, 1, 13), 32'hBFC0011C, 32'h00000400, 1, 32'h00008001, 1, 13, 32'hFFFF8001, n);
        issue(enc_i(6'h24, 1, 14), 32'hBFC00120, 32'h00000401, 1, 32'h0000A500, 1, 14, 32'h000000A5, n);
        issue(enc_r(4, 0, 2, 6'h09), 32'h00000100, 32'h0, 0, 0, 1, 2, 32'h00000108, n);

        idle();
        resp(32'h55555555, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
        chk("mid_rst_fwd_ready", 32'(fwd_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        resp(32'h77777777, 0);
        stall_load(enc_i(6'h23, 1, 12), 32'hBFC00200, 32'h00000500, 2, 32'h66666666, 12, 32'h66666666);

        idle();
        repeat (2) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
